// File: rtl/cardinal_dmem_arbiter.sv
// Round-robin arbiter sharing one synchronous 256x64 dmem between four node ports.
// Grant is combinational (0 cycles); rvalid/rdata follow one cycle after a granted read.
module cardinal_dmem_arbiter #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 64,
  parameter int BURST_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [0:3]        req,
  input  logic [0:3]        wr,
  input  logic [0:ADDR_W-1] addr0,
  input  logic [0:ADDR_W-1] addr1,
  input  logic [0:ADDR_W-1] addr2,
  input  logic [0:ADDR_W-1] addr3,
  input  logic [0:DATA_W-1] wdata0,
  input  logic [0:DATA_W-1] wdata1,
  input  logic [0:DATA_W-1] wdata2,
  input  logic [0:DATA_W-1] wdata3,
  output logic [0:3]        gnt,
  output logic [0:3]        rvalid,
  output logic [0:DATA_W-1] rdata,
  output logic              mem_en,
  output logic              mem_wr_en,
  output logic [0:ADDR_W-1] mem_addr,
  output logic [0:DATA_W-1] mem_din,
  input  logic [0:DATA_W-1] mem_dout
);

  localparam logic [3:0] BURST_LIM = 4'(BURST_MAX);

  logic       own_v;
  logic [1:0] own;
  logic [3:0] bcnt;
  logic [1:0] ptr;

  logic       others;
  logic       hold;
  logic       any_req;
  logic       found;
  logic       act;
  logic [1:0] win;
  logic [1:0] idx;
  logic [1:0] sel;
  logic [0:3] rvalid_nxt;
  logic [0:ADDR_W-1] addr_sel;
  logic [0:DATA_W-1] wdata_sel;

  always_comb begin
    others = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if ((i[1:0] != own) && req[i]) others = 1'b1;
    end
    hold    = own_v && req[own] && ((bcnt < BURST_LIM) || !others);
    any_req = |req;

    // First requester at or after ptr, wrapping modulo 4.
    win   = ptr;
    found = 1'b0;
    idx   = ptr;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + k[1:0];
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end

    sel = hold ? own : win;
    act = reset && any_req;

    case (sel)
      2'd0:    begin addr_sel = addr0; wdata_sel = wdata0; end
      2'd1:    begin addr_sel = addr1; wdata_sel = wdata1; end
      2'd2:    begin addr_sel = addr2; wdata_sel = wdata2; end
      default: begin addr_sel = addr3; wdata_sel = wdata3; end
    endcase

    gnt        = '0;
    rvalid_nxt = '0;
    if (act) begin
      gnt[sel] = 1'b1;
      if (!wr[sel]) rvalid_nxt[sel] = 1'b1;
    end

    mem_en    = act;
    mem_wr_en = act && wr[sel];
    mem_addr  = act ? addr_sel : '0;
    mem_din   = act ? wdata_sel : '0;
  end

  assign rdata = mem_dout;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      own_v  <= 1'b0;
      own    <= 2'd0;
      bcnt   <= 4'd0;
      ptr    <= 2'd0;
      rvalid <= '0;
    end else begin
      rvalid <= rvalid_nxt;
      if (hold) begin
        bcnt <= (bcnt == 4'hF) ? bcnt : bcnt + 4'd1;
      end else if (any_req) begin
        own   <= win;
        own_v <= 1'b1;
        bcnt  <= 4'd1;
        ptr   <= win + 2'd1;
      end else begin
        own_v <= 1'b0;
        bcnt  <= 4'd0;
      end
    end
  end

endmodule

// File: tb/tb_cardinal_dmem_arbiter.sv
// Directed bench for cardinal_dmem_arbiter: one instance at BURST_MAX=4 with a dmem model,
// a second at BURST_MAX=1 sharing the same requests for the strict rotation case.
module tb_cardinal_dmem_arbiter;

  logic        clk;
  logic        reset;
  logic [0:3]  req;
  logic [0:3]  wr;
  logic [0:7]  addr0, addr1, addr2, addr3;
  logic [0:63] wdata0, wdata1, wdata2, wdata3;

  logic [0:3]  gnt0, rvalid0;
  logic [0:63] rdata0, mem_din0, mem_dout0;
  logic [0:7]  mem_addr0;
  logic        mem_en0, mem_wr_en0;

  logic [0:3]  gnt1, rvalid1;
  logic [0:63] rdata1, mem_din1;
  logic [0:63] mem_dout1;
  logic [0:7]  mem_addr1;
  logic        mem_en1, mem_wr_en1;

  int checks = 0;
  int errors = 0;

  cardinal_dmem_arbiter #(.ADDR_W(8), .DATA_W(64), .BURST_MAX(4)) dut (
    .clk(clk), .reset(reset), .req(req), .wr(wr),
    .addr0(addr0), .addr1(addr1), .addr2(addr2), .addr3(addr3),
    .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2), .wdata3(wdata3),
    .gnt(gnt0), .rvalid(rvalid0), .rdata(rdata0),
    .mem_en(mem_en0), .mem_wr_en(mem_wr_en0), .mem_addr(mem_addr0),
    .mem_din(mem_din0), .mem_dout(mem_dout0)
  );

  cardinal_dmem_arbiter #(.ADDR_W(8), .DATA_W(64), .BURST_MAX(1)) dut_b1 (
    .clk(clk), .reset(reset), .req(req), .wr(wr),
    .addr0(addr0), .addr1(addr1), .addr2(addr2), .addr3(addr3),
    .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2), .wdata3(wdata3),
    .gnt(gnt1), .rvalid(rvalid1), .rdata(rdata1),
    .mem_en(mem_en1), .mem_wr_en(mem_wr_en1), .mem_addr(mem_addr1),
    .mem_din(mem_din1), .mem_dout(mem_dout1)
  );

  assign mem_dout1 = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // dmem model: unwritten words return a fixed address-derived pattern; DM[16] is preset.
  logic [63:0]  mem [256];
  logic [255:0] wv;

  function automatic logic [63:0] init_word(input logic [7:0] a);
    if (a == 8'd16) return 64'hDEADBEEF00000001;
    return {56'hC0FFEE00000000, a};
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      wv <= '0;
    end else if (mem_en0) begin
      if (mem_wr_en0) begin
        mem[mem_addr0] <= mem_din0;
        wv[mem_addr0]  <= 1'b1;
      end else begin
        mem_dout0 <= wv[mem_addr0] ? mem[mem_addr0] : init_word(mem_addr0);
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  logic [0:3] rr_exp [5];
  logic [0:3] b4_exp [5];

  initial begin
    reset = 1'b0;
    req = '0; wr = '0;
    addr0 = '0; addr1 = '0; addr2 = '0; addr3 = '0;
    wdata0 = '0; wdata1 = '0; wdata2 = '0; wdata3 = '0;

    // Reset: outputs held at zero even with a pending request.
    tick(); tick();
    req = 4'b1000; addr0 = 8'h10;
    #1;
    check("rst_gnt", gnt0, 4'b0000);
    check("rst_mem_en", mem_en0, 1'b0);
    check("rst_mem_wr_en", mem_wr_en0, 1'b0);
    check("rst_mem_addr", mem_addr0, 8'h00);
    check("rst_rvalid", rvalid0, 4'b0000);
    check("rst_gnt_b1", gnt1, 4'b0000);
    tick(); tick(); tick();

    // Single read granted in the first cycle out of reset.
    reset = 1'b1;
    #1;
    check("t1_gnt", gnt0, 4'b1000);
    check("t1_mem_en", mem_en0, 1'b1);
    check("t1_mem_wr_en", mem_wr_en0, 1'b0);
    check("t1_mem_addr", mem_addr0, 8'h10);
    tick();
    req = 4'b0000;
    #1;
    check("t1_rvalid", rvalid0, 4'b1000);
    check("t1_rdata", rdata0, 64'hDEADBEEF00000001);
    check("t1_idle_gnt", gnt0, 4'b0000);
    check("t1_idle_mem_addr", mem_addr0, 8'h00);
    tick();
    #1;
    check("t1_rvalid_once", rvalid0, 4'b0000);
    reset = 1'b0;
    tick();
    reset = 1'b1;

    // Round robin with all four reading; BURST_MAX=1 rotates, BURST_MAX=4 holds node 0.
    rr_exp[0] = 4'b1000; rr_exp[1] = 4'b0100; rr_exp[2] = 4'b0010;
    rr_exp[3] = 4'b0001; rr_exp[4] = 4'b1000;
    b4_exp[0] = 4'b1000; b4_exp[1] = 4'b1000; b4_exp[2] = 4'b1000;
    b4_exp[3] = 4'b1000; b4_exp[4] = 4'b0100;
    req = 4'b1111; wr = 4'b0000;
    addr0 = 8'h01; addr1 = 8'h02; addr2 = 8'h03; addr3 = 8'h04;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("t2_rr_gnt%0d", k), gnt1, rr_exp[k]);
      check($sformatf("t2_b4_gnt%0d", k), gnt0, b4_exp[k]);
      if (k > 0) check($sformatf("t2_rr_rvalid%0d", k), rvalid1, rr_exp[k-1]);
      tick();
    end
    req = 4'b0000;
    #1;
    check("t2_rr_rvalid_last", rvalid1, 4'b1000);
    tick();

    // Burst limit: node 1 continuous, node 3 joins at cycle 2.
    req = 4'b0100; addr1 = 8'h21; addr3 = 8'h33;
    for (int k = 0; k < 2; k++) begin
      #1;
      check($sformatf("t3_solo_gnt%0d", k), gnt0, 4'b0100);
      tick();
    end
    req = 4'b0101;
    for (int k = 2; k < 4; k++) begin
      #1;
      check($sformatf("t3_burst_gnt%0d", k), gnt0, 4'b0100);
      tick();
    end
    #1;
    check("t3_switch_gnt", gnt0, 4'b0001);
    check("t3_switch_addr", mem_addr0, 8'h33);
    tick();
    req = 4'b0100;
    for (int k = 0; k < 20; k++) begin
      #1;
      check($sformatf("t3_lone_gnt%0d", k), gnt0, 4'b0100);
      if (k == 0) begin
        check("t3_n3_rvalid", rvalid0, 4'b0001);
        check("t3_n3_rdata", rdata0, {56'hC0FFEE00000000, 8'h33});
      end
      tick();
    end
    req = 4'b0000;
    #1;
    check("t3_end_gnt", gnt0, 4'b0000);
    check("t3_end_rvalid", rvalid0, 4'b0100);
    tick();

    // Write then read same address, then write again: read sees first write only.
    req = 4'b0010; wr = 4'b0010; addr2 = 8'h05; wdata2 = 64'h0123456789ABCDEF;
    #1;
    check("t4_wr_gnt", gnt0, 4'b0010);
    check("t4_wr_en", mem_wr_en0, 1'b1);
    check("t4_wr_addr", mem_addr0, 8'h05);
    check("t4_wr_din", mem_din0, 64'h0123456789ABCDEF);
    tick();
    wr = 4'b0000;
    #1;
    check("t4_rd_gnt", gnt0, 4'b0010);
    check("t4_rd_wr_en", mem_wr_en0, 1'b0);
    check("t4_wr_no_rvalid", rvalid0, 4'b0000);
    tick();
    wr = 4'b0010; wdata2 = 64'hFFFF0000FFFF0000;
    #1;
    check("t4_rd_rvalid", rvalid0, 4'b0010);
    check("t4_rd_rdata", rdata0, 64'h0123456789ABCDEF);
    check("t4_wr2_gnt", gnt0, 4'b0010);
    tick();
    req = 4'b0000; wr = 4'b0000;
    #1;
    check("t4_wr2_no_rvalid", rvalid0, 4'b0000);
    tick();

    // Reset asserted between edges while node 0 holds a read grant.
    req = 4'b1000; addr0 = 8'h10;
    #1;
    check("t5_pre_gnt", gnt0, 4'b1000);
    #2;
    reset = 1'b0;
    #1;
    check("t5_async_gnt", gnt0, 4'b0000);
    check("t5_async_mem_en", mem_en0, 1'b0);
    tick();
    #1;
    check("t5_no_rvalid", rvalid0, 4'b0000);
    reset = 1'b1;
    req = 4'b0101; addr1 = 8'h41; addr3 = 8'h43;
    #1;
    check("t5_ptr_restart_gnt", gnt0, 4'b0100);
    tick();
    req = 4'b0001;
    #1;
    check("t5_n3_gnt", gnt0, 4'b0001);
    check("t5_n1_rvalid", rvalid0, 4'b0100);
    tick();

    // Idle after a node-3 grant, then ptr must have wrapped to 0.
    req = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("t6_idle_mem_en%0d", k), mem_en0, 1'b0);
      check($sformatf("t6_idle_gnt%0d", k), gnt0, 4'b0000);
      tick();
    end
    req = 4'b1001; addr0 = 8'h10; addr3 = 8'h07;
    #1;
    check("t6_wrap_gnt", gnt0, 4'b1000);
    tick();
    req = 4'b0001;
    #1;
    check("t6_n3_gnt", gnt0, 4'b0001);
    check("t6_n0_rvalid", rvalid0, 4'b1000);
    check("t6_n0_rdata", rdata0, 64'hDEADBEEF00000001);
    tick();
    req = 4'b0000;
    #1;
    check("t6_n3_rvalid", rvalid0, 4'b0001);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
